// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the I/D memory bus arbiter: owner encoding,
//   FSM state type and the default read data returned on a timed-out
//   transaction.
package mem_bus_arbiter_pkg;

  // Owner encoding on oOwner
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// bus_timeout_counter
//   Counts cycles while enabled and flags the cycle in which the count
//   reaches limit-1, i.e. the last cycle allowed before an abort.
//   A limit of 0 never expires.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clear       synchronous clear of the count (wins over enable)
//   enable      count this cycle; expired is only asserted while enabled
//   limit       number of enabled cycles allowed (0 = unlimited)
//   expired     combinational: enabled and count == limit-1
module bus_timeout_counter #(
  parameter int TIMEOUT = 255,
  parameter int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = enable && (limit != '0) && (cnt_q == limit - ONE);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory port between the instruction-fetch (I) and data (D)
//   requesters. The winning request is latched onto oMem*, held through
//   BUSY until iMemAck (or a timeout abort), then the owner gets a single
//   cycle ack in RESP with its read data.
// Ports:
//   iCLK, iRST_N                     clock / async active-low reset
//   iIReq..iIBE, oIAck, oIRData      instruction requester
//   iDReq..iDBE, oDAck, oDRData      data requester
//   oMemReq..oMemBE, iMemAck/RData   shared memory port
//   oBusy, oOwner                    status (oOwner: 0 = I, 1 = D)
//   oTimeout, iClrErr                sticky abort flag and its clear
// Configuration:
//   ARB_ROUND_ROBIN_EN  defined: ties go to the requester not granted last.
//                       undefined: D wins ties.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iIReq,
  input  logic                iIWrite,
  input  logic [ADDR_W-1:0]   iIAddr,
  input  logic [DATA_W-1:0]   iIWData,
  input  logic [DATA_W/8-1:0] iIBE,
  output logic                oIAck,
  output logic [DATA_W-1:0]   oIRData,
  input  logic                iDReq,
  input  logic                iDWrite,
  input  logic [ADDR_W-1:0]   iDAddr,
  input  logic [DATA_W-1:0]   iDWData,
  input  logic [DATA_W/8-1:0] iDBE,
  output logic                oDAck,
  output logic [DATA_W-1:0]   oDRData,
  output logic                oMemReq,
  output logic                oMemWrite,
  output logic [ADDR_W-1:0]   oMemAddr,
  output logic [DATA_W-1:0]   oMemWData,
  output logic [DATA_W/8-1:0] oMemBE,
  input  logic                iMemAck,
  input  logic [DATA_W-1:0]   iMemRData,
  output logic                oBusy,
  output logic                oOwner,
  output logic                oTimeout,
  input  logic                iClrErr
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              timeout_q, timeout_d;
  logic              timeout_set;
  logic              grant_d;
  logic              cnt_clear, cnt_en, expired;

  // Winner on this edge: 1 = D. owner_q doubles as the last-granted
  // register for round robin, so a tie after reset goes to D.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (iIReq && iDReq) grant_d = ~owner_q;
    else                grant_d = iDReq;
`else
    grant_d = iDReq;
`endif
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    timeout_set = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (iIReq || iDReq) begin
          owner_d     = grant_d;
          mem_write_d = grant_d ? iDWrite : iIWrite;
          mem_addr_d  = grant_d ? iDAddr  : iIAddr;
          mem_wdata_d = grant_d ? iDWData : iIWData;
          mem_be_d    = grant_d ? iDBE    : iIBE;
          cnt_clear   = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_en = 1'b1;
        // Ack is checked first so it wins over a coincident timeout.
        if (iMemAck) begin
          if (owner_q == OWN_D) d_rdata_d = iMemRData;
          else                  i_rdata_d = iMemRData;
          state_d = RESP;
        end else if (expired) begin
          if (owner_q == OWN_D) d_rdata_d = ERR_DATA;
          else                  i_rdata_d = ERR_DATA;
          timeout_set = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new abort beats a clear on the same edge.
    if (timeout_set)  timeout_d = 1'b1;
    else if (iClrErr) timeout_d = 1'b0;
    else              timeout_d = timeout_q;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .limit   (LIMIT),
    .expired (expired)
  );

  // Outputs decode straight from flops; reset clears them asynchronously.
  assign oMemReq   = (state_q == BUSY);
  assign oBusy     = (state_q != IDLE);
  assign oIAck     = (state_q == RESP) && (owner_q == OWN_I);
  assign oDAck     = (state_q == RESP) && (owner_q == OWN_D);
  assign oIRData   = i_rdata_q;
  assign oDRData   = d_rdata_q;
  assign oMemWrite = mem_write_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemWData = mem_wdata_q;
  assign oMemBE    = mem_be_q;
  assign oOwner    = owner_q;
  assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed scenarios plus a randomized transaction loop, checked against
//   a transaction-level model: who wins, when the ack lands, what data the
//   owner sees, and the sticky timeout flag. DUT built with TIMEOUT=4.
module tb_mem_bus_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, TO = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          iCLK, iRST_N;
  logic          iIReq, iIWrite, iDReq, iDWrite;
  logic [AW-1:0] iIAddr, iDAddr;
  logic [DW-1:0] iIWData, iDWData;
  logic [BW-1:0] iIBE, iDBE;
  logic          oIAck, oDAck;
  logic [DW-1:0] oIRData, oDRData;
  logic          oMemReq, oMemWrite;
  logic [AW-1:0] oMemAddr;
  logic [DW-1:0] oMemWData;
  logic [BW-1:0] oMemBE;
  logic          iMemAck;
  logic [DW-1:0] iMemRData;
  logic          oBusy, oOwner, oTimeout, iClrErr;

  int n_chk = 0, n_pass = 0;

  // Model state: sticky flag, per-requester held read data, last grantee
  logic          exp_to;
  logic [DW-1:0] exp_ir, exp_dr;
  logic          last_own;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iIReq(iIReq), .iIWrite(iIWrite), .iIAddr(iIAddr), .iIWData(iIWData), .iIBE(iIBE),
    .oIAck(oIAck), .oIRData(oIRData),
    .iDReq(iDReq), .iDWrite(iDWrite), .iDAddr(iDAddr), .iDWData(iDWData), .iDBE(iDBE),
    .oDAck(oDAck), .oDRData(oDRData),
    .oMemReq(oMemReq), .oMemWrite(oMemWrite), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .oMemBE(oMemBE), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oBusy(oBusy), .oOwner(oOwner), .oTimeout(oTimeout), .iClrErr(iClrErr)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Every drive and sample happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic model_reset();
    exp_to = 1'b0; exp_ir = '0; exp_dr = '0; last_own = 1'b0;
  endtask

  task automatic test_reset();
    iRST_N = 1'b0; iClrErr = 1'b0; iMemAck = 1'b0; iMemRData = '0;
    iIReq = 1'b0; iIWrite = 1'b0; iIAddr = '0; iIWData = '0; iIBE = '0;
    iDReq = 1'b0; iDWrite = 1'b0; iDAddr = '0; iDWData = '0; iDBE = '0;
    model_reset();
    #12;
    n_chk++;
    if ({oIAck, oDAck, oMemReq, oMemWrite, oBusy, oOwner, oTimeout, oMemBE} !== '0 ||
        {oIRData, oDRData, oMemAddr, oMemWData} !== '0)
      $display("FAIL reset_outputs: ctl=%b data=%h want all zero",
               {oIAck, oDAck, oMemReq, oMemWrite, oBusy, oOwner, oTimeout, oMemBE},
               {oIRData, oDRData, oMemAddr, oMemWData});
    else n_pass++;
    iRST_N = 1'b1;
    tick();
    n_chk++;
    if ({oBusy, oMemReq, oIAck, oDAck} !== 4'b0) $display("FAIL reset_idle: got %b want 0000", {oBusy, oMemReq, oIAck, oDAck});
    else n_pass++;
  endtask

  task automatic test_single_read();
    iDReq = 1'b1; iDWrite = 1'b0; iDAddr = 32'h100; iDBE = 4'hF;
    tick();  // sampled -> BUSY cycle 1
    n_chk++;
    if ({oMemReq, oMemWrite, oOwner, oDAck} !== 4'b1010 || oMemAddr !== 32'h100)
      $display("FAIL rd_busy: req/wr/own/ack=%b addr=%h want 1010 00000100", {oMemReq, oMemWrite, oOwner, oDAck}, oMemAddr);
    else n_pass++;
    iMemAck = 1'b1; iMemRData = 32'h12345678;
    tick();  // RESP
    iMemAck = 1'b0; iDReq = 1'b0;
    last_own = 1'b1; exp_dr = 32'h12345678;
    n_chk++;
    if ({oDAck, oIAck, oMemReq} !== 3'b100 || oDRData !== 32'h12345678)
      $display("FAIL rd_ack: dack/iack/req=%b data=%h want 100 12345678", {oDAck, oIAck, oMemReq}, oDRData);
    else n_pass++;
    tick();
    n_chk++;
    if ({oDAck, oBusy} !== 2'b00 || oDRData !== exp_dr)
      $display("FAIL rd_hold: dack/busy=%b data=%h want 00 %h", {oDAck, oBusy}, oDRData, exp_dr);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    int grants;
    logic own;
    logic [31:0] rd;
    grants = RR ? 4 : 2;
    iIReq = 1'b1; iIWrite = 1'b0; iIAddr = 32'h1000; iIBE = 4'hF;
    iDReq = 1'b1; iDWrite = 1'b0; iDAddr = 32'h2000; iDBE = 4'hF;
    for (int g = 0; g < grants; g++) begin
      own = (iIReq && iDReq) ? (RR ? ~last_own : 1'b1) : iDReq;
      tick();
      n_chk++;
      if (oOwner !== own || oMemAddr !== (own ? 32'h2000 : 32'h1000))
        $display("FAIL arb_grant%0d: owner=%b addr=%h want %b", g, oOwner, oMemAddr, own);
      else n_pass++;
      rd = 32'hC0DE0000 | 32'(g);
      iMemAck = 1'b1; iMemRData = rd;
      tick();
      iMemAck = 1'b0;
      last_own = own;
      if (own) exp_dr = rd; else exp_ir = rd;
      n_chk++;
      if ({oDAck, oIAck} !== (own ? 2'b10 : 2'b01) || (own ? oDRData : oIRData) !== rd)
        $display("FAIL arb_ack%0d: dack/iack=%b data=%h want owner %b data %h", g, {oDAck, oIAck},
                 own ? oDRData : oIRData, own, rd);
      else n_pass++;
      if (!RR && own) iDReq = 1'b0;
      if (g == grants - 1) begin iIReq = 1'b0; iDReq = 1'b0; end
      tick();
    end
  endtask

  task automatic test_write();
    iDReq = 1'b1; iDWrite = 1'b1; iDAddr = 32'h200; iDWData = 32'hA5A5A5A5; iDBE = 4'b0011;
    tick();
    iDWData = 32'h0; iDBE = 4'hF;  // port must keep the latched values
    n_chk++;
    if ({oMemReq, oMemWrite} !== 2'b11 || oMemBE !== 4'b0011 || oMemWData !== 32'hA5A5A5A5 || oMemAddr !== 32'h200)
      $display("FAIL wr_port: req/wr=%b be=%b wdata=%h addr=%h want 11 0011 a5a5a5a5 00000200",
               {oMemReq, oMemWrite}, oMemBE, oMemWData, oMemAddr);
    else n_pass++;
    tick();  // memory waits one cycle
    iMemAck = 1'b1; iMemRData = exp_dr;
    tick();
    iMemAck = 1'b0; iDReq = 1'b0; last_own = 1'b1;
    n_chk++;
    if ({oDAck, oIAck, oMemReq} !== 3'b100) $display("FAIL wr_ack: dack/iack/req=%b want 100", {oDAck, oIAck, oMemReq});
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    iIReq = 1'b1; iIWrite = 1'b0; iIAddr = 32'h40; iIBE = 4'hF;
    tick();
    for (int n = 1; n <= TO; n++) begin
      n_chk++;
      if ({oMemReq, oIAck, oDAck} !== 3'b100) $display("FAIL to_busy%0d: req/iack/dack=%b want 100", n, {oMemReq, oIAck, oDAck});
      else n_pass++;
      tick();
    end
    iIReq = 1'b0; last_own = 1'b0; exp_ir = ERR; exp_to = 1'b1;
    n_chk++;
    if ({oIAck, oTimeout, oMemReq} !== 3'b110 || oIRData !== ERR)
      $display("FAIL to_abort: iack/to/req=%b data=%h want 110 deadbeef", {oIAck, oTimeout, oMemReq}, oIRData);
    else n_pass++;
    tick(); tick();
    n_chk++;
    if ({oTimeout, oBusy} !== 2'b10) $display("FAIL to_sticky: to/busy=%b want 10", {oTimeout, oBusy});
    else n_pass++;
    iClrErr = 1'b1;
    tick();
    iClrErr = 1'b0; exp_to = 1'b0;
    n_chk++;
    if (oTimeout !== 1'b0) $display("FAIL to_clear: got %b want 0", oTimeout);
    else n_pass++;
    // Clear held throughout a second abort: the set edge must win.
    iClrErr = 1'b1; iIReq = 1'b1;
    tick();
    for (int n = 1; n <= TO; n++) tick();
    iIReq = 1'b0;
    n_chk++;
    if ({oIAck, oTimeout} !== 2'b11) $display("FAIL to_set_wins: iack/to=%b want 11", {oIAck, oTimeout});
    else n_pass++;
    tick();
    iClrErr = 1'b0;
    n_chk++;
    if (oTimeout !== 1'b0) $display("FAIL to_clear2: got %b want 0", oTimeout);
    else n_pass++;
    // Ack on the last allowed cycle beats the timeout.
    iIReq = 1'b1;
    tick();
    for (int n = 1; n <= TO; n++) begin
      if (n == TO) begin iMemAck = 1'b1; iMemRData = 32'h0000600D; end
      tick();
    end
    iMemAck = 1'b0; iIReq = 1'b0; exp_ir = 32'h0000600D;
    n_chk++;
    if ({oIAck, oTimeout} !== 2'b10 || oIRData !== 32'h0000600D)
      $display("FAIL to_ack_wins: iack/to=%b data=%h want 10 0000600d", {oIAck, oTimeout}, oIRData);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    iDReq = 1'b1; iDWrite = 1'b0; iDAddr = 32'h340;
    tick(); tick();
    #2 iRST_N = 1'b0;
    #1;
    n_chk++;
    if ({oMemReq, oBusy} !== 2'b00) $display("FAIL arst_drop: req/busy=%b want 00", {oMemReq, oBusy});
    else n_pass++;
    model_reset();
    iDReq = 1'b0;
    #1 iRST_N = 1'b1;
    iMemAck = 1'b1; iMemRData = 32'hBADBAD00;
    for (int n = 0; n < 3; n++) begin
      tick();
      n_chk++;
      if ({oIAck, oDAck, oBusy} !== 3'b000) $display("FAIL arst_noack%0d: iack/dack/busy=%b want 000", n, {oIAck, oDAck, oBusy});
      else n_pass++;
    end
    iMemAck = 1'b0;
    iIReq = 1'b1; iIWrite = 1'b0; iIAddr = 32'h44;
    tick();
    iMemAck = 1'b1; iMemRData = 32'h13572468;
    tick();
    iMemAck = 1'b0; iIReq = 1'b0; exp_ir = 32'h13572468; last_own = 1'b0;
    n_chk++;
    if ({oIAck, oDAck} !== 2'b10 || oIRData !== exp_ir)
      $display("FAIL arst_after: iack/dack=%b data=%h want 10 %h", {oIAck, oDAck}, oIRData, exp_ir);
    else n_pass++;
    tick();
  endtask

  task automatic test_idle_ack_drop();
    iMemAck = 1'b1; iMemRData = 32'hBAD0BAD0;
    tick();
    iMemAck = 1'b0;
    n_chk++;
    if ({oBusy, oIAck, oDAck} !== 3'b000 || {oIRData, oDRData} !== {exp_ir, exp_dr})
      $display("FAIL idle_ack: busy/iack/dack=%b rdata=%h want 000 %h", {oBusy, oIAck, oDAck}, {oIRData, oDRData}, {exp_ir, exp_dr});
    else n_pass++;
    iDReq = 1'b1; iDWrite = 1'b0; iDAddr = 32'h300;
    tick();
    iDReq = 1'b0;  // dropped after being latched
    tick();
    n_chk++;
    if ({oMemReq, oOwner} !== 2'b11) $display("FAIL drop_busy: req/own=%b want 11", {oMemReq, oOwner});
    else n_pass++;
    iMemAck = 1'b1; iMemRData = 32'h000055AA;
    tick();
    iMemAck = 1'b0; exp_dr = 32'h000055AA; last_own = 1'b1;
    n_chk++;
    if (oDAck !== 1'b1 || oDRData !== exp_dr) $display("FAIL drop_ack: dack=%b data=%h want 1 %h", oDAck, oDRData, exp_dr);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic        ir, dr, own, wr, clr;
    logic [31:0] a, wd, rd, exp_rd;
    logic [3:0]  be;
    int          pat, lat, n;
    for (int t = 0; t < 40; t++) begin
      pat = $urandom_range(1, 3);
      ir = pat[0]; dr = pat[1];
      iIReq = ir; iIWrite = 1'($urandom_range(0, 1)); iIAddr = $urandom; iIWData = $urandom; iIBE = 4'($urandom);
      iDReq = dr; iDWrite = 1'($urandom_range(0, 1)); iDAddr = $urandom; iDWData = $urandom; iDBE = 4'($urandom);
      clr = ($urandom_range(0, 3) == 0);
      iClrErr = clr;
      if (clr) exp_to = 1'b0;
      own = (ir && dr) ? (RR ? ~last_own : 1'b1) : dr;
      wr = own ? iDWrite : iIWrite;
      a  = own ? iDAddr  : iIAddr;
      wd = own ? iDWData : iIWData;
      be = own ? iDBE    : iIBE;
      lat = $urandom_range(1, TO + 1);  // TO+1: memory never answers
      tick();
      iClrErr = 1'b0;
      last_own = own;
      n_chk++;
      if ({oOwner, oMemWrite, oMemAddr, oMemWData, oMemBE} !== {own, wr, a, wd, be})
        $display("FAIL rnd_port%0d: got %b %b %h %h %b want %b %b %h %h %b", t, oOwner, oMemWrite, oMemAddr,
                 oMemWData, oMemBE, own, wr, a, wd, be);
      else n_pass++;
      rd = wr ? (own ? exp_dr : exp_ir) : $urandom;
      n = 1;
      while (1) begin
        n_chk++;
        if ({oMemReq, oIAck, oDAck} !== 3'b100) $display("FAIL rnd_busy%0d: req/iack/dack=%b want 100", t, {oMemReq, oIAck, oDAck});
        else n_pass++;
        if (n == lat) begin iMemAck = 1'b1; iMemRData = rd; end
        tick();
        iMemAck = 1'b0;
        if (n == lat || n == TO) break;
        n++;
      end
      exp_rd = (lat <= TO) ? rd : ERR;
      if (lat > TO) exp_to = 1'b1;
      if (own) exp_dr = exp_rd; else exp_ir = exp_rd;
      n_chk++;
      if ({oIAck, oDAck, oMemReq, oTimeout} !== {~own, own, 1'b0, exp_to} || (own ? oDRData : oIRData) !== exp_rd)
        $display("FAIL rnd_resp%0d: iack/dack/req/to=%b data=%h want %b data %h", t, {oIAck, oDAck, oMemReq, oTimeout},
                 own ? oDRData : oIRData, {~own, own, 1'b0, exp_to}, exp_rd);
      else n_pass++;
      iIReq = 1'b0; iDReq = 1'b0;
      tick();
      n_chk++;
      if ({oBusy, oIAck, oDAck} !== 3'b000 || {oIRData, oDRData} !== {exp_ir, exp_dr})
        $display("FAIL rnd_idle%0d: busy/acks=%b rdata=%h want 000 %h", t, {oBusy, oIAck, oDAck}, {oIRData, oDRData}, {exp_ir, exp_dr});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single_read();
    test_write();
    test_timeout();
    test_async_reset();
    test_idle_ack_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
